// File: rtl/video_timing_pkg.sv
// Shared 720p60 raster constants, FSM state type and counter width for
// hdmi_video_timing and its lock/settle front end.
package video_timing_pkg;

   localparam int VT_CNT_W = 12;

   localparam int H_ACTIVE_720P = 1280;
   localparam int H_FP_720P     = 110;
   localparam int H_SYNC_720P   = 40;
   localparam int H_BP_720P     = 220;
   localparam int V_ACTIVE_720P = 720;
   localparam int V_FP_720P     = 5;
   localparam int V_SYNC_720P   = 5;
   localparam int V_BP_720P     = 20;

   localparam int H_TOTAL_720P = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
   localparam int V_TOTAL_720P = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

   typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} vt_state_t;

endpackage

// File: rtl/lock_settle.sv
// Synchronizes PLL lock into the pixel clock domain and holds off the raster
// until lock has been stable for SETTLE_CYCLES cycles.
module lock_settle
   import video_timing_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic locked,
   output logic start_ok
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("lock_settle: SETTLE_CYCLES must be at least 1");
   end

   logic [1:0]    sync_q;
   logic          locked_s;
   vt_state_t     state, state_nxt;
   logic [SW-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[0], locked};
   end

   assign locked_s = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WAIT_LOCK;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         WAIT_LOCK: begin
            cnt_nxt = '0;
            if (locked_s) state_nxt = SETTLE;
         end
         SETTLE: begin
            cnt_nxt = cnt + 1'b1;
            if (!locked_s)               state_nxt = WAIT_LOCK;
            else if (cnt == SETTLE_LAST) state_nxt = RUN;
         end
         RUN: begin
            if (!locked_s) state_nxt = WAIT_LOCK;
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   // Gating with locked_s lets the raster stop on the same edge the FSM leaves RUN.
   assign start_ok = (state == RUN) && locked_s;

endmodule

// File: rtl/hdmi_video_timing.sv
// CEA-861 raster timing generator (720p60 defaults) gated by PLL lock.
// Define HDMI_VIDEO_TIMING_FRAME_CNT_EN to build the frame counter.
module hdmi_video_timing
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE      = H_ACTIVE_720P,
   parameter int H_FP          = H_FP_720P,
   parameter int H_SYNC        = H_SYNC_720P,
   parameter int H_BP          = H_BP_720P,
   parameter int V_ACTIVE      = V_ACTIVE_720P,
   parameter int V_FP          = V_FP_720P,
   parameter int V_SYNC        = V_SYNC_720P,
   parameter int V_BP          = V_BP_720P,
   parameter bit HS_POL        = 1'b1,
   parameter bit VS_POL        = 1'b1,
   parameter int SETTLE_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                locked,
   output logic                hsync,
   output logic                vsync,
   output logic                de,
   output logic [VT_CNT_W-1:0] pixel_x,
   output logic [VT_CNT_W-1:0] pixel_y,
   output logic                frame_start,
   output logic                running,
   output logic [15:0]         frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > (1 << VT_CNT_W) || V_TOTAL > (1 << VT_CNT_W)) begin : g_bad_total
      $error("hdmi_video_timing: H_TOTAL/V_TOTAL exceed 12-bit counter range");
   end

   localparam logic [VT_CNT_W-1:0] H_ACT_C  = VT_CNT_W'(H_ACTIVE);
   localparam logic [VT_CNT_W-1:0] H_SS_C   = VT_CNT_W'(H_ACTIVE + H_FP);
   localparam logic [VT_CNT_W-1:0] H_SE_C   = VT_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VT_CNT_W-1:0] H_LAST_C = VT_CNT_W'(H_TOTAL - 1);
   localparam logic [VT_CNT_W-1:0] V_ACT_C  = VT_CNT_W'(V_ACTIVE);
   localparam logic [VT_CNT_W-1:0] V_SS_C   = VT_CNT_W'(V_ACTIVE + V_FP);
   localparam logic [VT_CNT_W-1:0] V_SE_C   = VT_CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VT_CNT_W-1:0] V_LAST_C = VT_CNT_W'(V_TOTAL - 1);

   logic                start_ok;
   logic [VT_CNT_W-1:0] h, v;
   logic                act, hs_act, vs_act, origin;

   lock_settle #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_lock_settle (
      .clk      (clk),
      .rst_n    (rst_n),
      .locked   (locked),
      .start_ok (start_ok)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h <= '0;
         v <= '0;
      end else if (!start_ok) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST_C) begin
         h <= '0;
         v <= (v == V_LAST_C) ? '0 : v + 1'b1;
      end else begin
         h <= h + 1'b1;
      end
   end

   assign act    = (h < H_ACT_C) && (v < V_ACT_C);
   assign hs_act = (h >= H_SS_C) && (h < H_SE_C);
   assign vs_act = (v >= V_SS_C) && (v < V_SE_C);
   assign origin = (h == '0) && (v == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         frame_start <= 1'b0;
         running     <= 1'b0;
      end else begin
         hsync       <= (start_ok && hs_act) ? HS_POL : ~HS_POL;
         vsync       <= (start_ok && vs_act) ? VS_POL : ~VS_POL;
         de          <= start_ok && act;
         pixel_x     <= (start_ok && act) ? h : '0;
         pixel_y     <= (start_ok && act) ? v : '0;
         frame_start <= start_ok && origin;
         running     <= start_ok;
      end
   end

`ifdef HDMI_VIDEO_TIMING_FRAME_CNT_EN
   // Advances on the same edge that raises frame_start, so both read together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  frame_cnt <= '0;
      else if (start_ok && origin) frame_cnt <= frame_cnt + 16'd1;
   end
`else
   assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Directed bench for hdmi_video_timing on a small 16x8 raster with a short
// settle interval; exercises start-up, one full frame, lock loss, glitch and reset.
module tb_hdmi_video_timing;

   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int SETTLE = 20;

`ifdef HDMI_VIDEO_TIMING_FRAME_CNT_EN
   localparam int FC_EN = 1;
`else
   localparam int FC_EN = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        locked = 1'b0;
   logic        hsync, vsync, de, frame_start, running;
   logic [11:0] pixel_x, pixel_y;
   logic [15:0] frame_cnt;

   int checks = 0;
   int errors = 0;
   int k;

   hdmi_video_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b1), .VS_POL(1'b0), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .locked(locked),
      .hsync(hsync), .vsync(vsync), .de(de),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .frame_start(frame_start), .running(running), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Counts edges (first edge after the call = 1) until running is seen high.
   task automatic wait_run(output int n);
      n = 0;
      while (!running && n < 200) begin
         step(1);
         n++;
      end
   endtask

   // Idle vector {running,frame_start,de,hsync,vsync,pixel_x,pixel_y}; vsync is active-low here.
   function automatic logic [28:0] idle_vec();
      return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 12'd0};
   endfunction

   function automatic logic [28:0] out_vec();
      return {running, frame_start, de, hsync, vsync, pixel_x, pixel_y};
   endfunction

   initial begin
      int h, v;
      logic e_de, e_hs, e_vs, e_fs;

      // reset state, lock already present
      locked = 1'b1;
      step(3);
      chk("reset_idle", out_vec(), idle_vec());
      chk("reset_fcnt", frame_cnt, 0);

      // release: edge 1 samples lock; running rises 2+SETTLE+1 edges after it
      rst_n = 1'b1;
      wait_run(k);
      chk("start_latency", k, SETTLE + 4);
      chk("start_first_px", {frame_start, de, pixel_x, pixel_y}, {1'b1, 1'b1, 12'd0, 12'd0});
      chk("start_fcnt", frame_cnt, FC_EN * 1);

      // one full frame against a raster model
      for (int i = 0; i < HT * VT; i++) begin
         h = i % HT;
         v = i / HT;
         e_de = (h < HA) && (v < VA);
         e_hs = (h >= HA + HF) && (h < HA + HF + HS);
         e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
         e_fs = (h == 0) && (v == 0);
         chk("frame", out_vec(),
             {1'b1, e_fs, e_de, e_hs, e_vs,
              e_de ? 12'(h) : 12'd0, e_de ? 12'(v) : 12'd0});
         step(1);
      end
      chk("frame_period", frame_start, 1'b1);
      chk("frame2_fcnt", frame_cnt, FC_EN * 2);

      // lock loss mid-frame at (6,2)
      step(2 * HT + 6);
      chk("pre_loss_pos", {de, pixel_x, pixel_y}, {1'b1, 12'd6, 12'd2});
      locked = 1'b0;
      step(2);
      chk("loss_still_run", running, 1'b1);
      step(1);
      chk("loss_idle", out_vec(), idle_vec());
      chk("loss_fcnt_held", frame_cnt, FC_EN * 2);

      // re-lock: full settle, raster restarts at origin
      locked = 1'b1;
      wait_run(k);
      chk("relock_latency", k, SETTLE + 4);
      chk("relock_origin", {frame_start, de, pixel_x, pixel_y}, {1'b1, 1'b1, 12'd0, 12'd0});
      chk("relock_fcnt", frame_cnt, FC_EN * 3);

      // one-cycle glitch during settle restarts the count
      locked = 1'b0;
      step(4);
      chk("glitch_pre_idle", running, 1'b0);
      locked = 1'b1;
      step(12);
      chk("glitch_in_settle", running, 1'b0);
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      wait_run(k);
      chk("glitch_latency", k, SETTLE + 4);
      chk("glitch_origin", {frame_start, pixel_x, pixel_y}, {1'b1, 12'd0, 12'd0});

      // asynchronous reset while hsync and vsync are both active (h=11, v=5)
      step(5 * HT + 11);
      chk("pre_rst_sync", {running, hsync, vsync}, 3'b110);
      rst_n = 1'b0;
      #1;
      chk("async_rst_idle", out_vec(), idle_vec());
      chk("async_rst_fcnt", frame_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
